// File: rtl/fp32_add_mul_unit_if.sv
// fp32_add_mul_unit_if: operand/result bundle for the binary32 add/multiply pair.
// The master drives the four operands and observes sum (combinational) and
// p (registered); the slave is the arithmetic unit itself.
interface fp32_add_mul_unit_if;
  logic [31:0] add_a;
  logic [31:0] add_b;
  logic [31:0] sum;
  logic [31:0] mul_a;
  logic [31:0] mul_b;
  logic [31:0] p;

  modport master (
    output add_a, add_b, mul_a, mul_b,
    input  sum, p
  );

  modport slave (
    input  add_a, add_b, mul_a, mul_b,
    output sum, p
  );
endinterface

// File: rtl/fp32_add_mul_unit.sv
// fp32_add_mul_unit: IEEE-754 binary32 adder (combinational) and multiplier
// (one output register) for the neuron datapath.
// Subnormal operands read as signed zero; subnormal results flush to signed zero.
// Build option: define FP_ROUND_NEAREST_EN for round-to-nearest-even with
// overflow to Inf; otherwise results truncate toward zero and overflow
// saturates to the largest finite magnitude.
module fp32_add_mul_unit (
  input  logic                       clk,
  input  logic                       rst,
  fp32_add_mul_unit_if.slave         bus
);

  localparam logic [31:0] QNAN = 32'h7FC0_0000;

`ifdef FP_ROUND_NEAREST_EN
  localparam bit          ROUND_NEAREST = 1'b1;
  localparam logic [30:0] OVF_MAG       = 31'h7F80_0000;
`else
  localparam bit          ROUND_NEAREST = 1'b0;
  localparam logic [30:0] OVF_MAG       = 31'h7F7F_FFFF;
`endif

  // Count leading zeros of a 27-bit value; returns 27 when the value is zero.
  function automatic logic [4:0] lzc27(input logic [26:0] v);
    logic [4:0] n;
    logic       found;
    n     = 5'd27;
    found = 1'b0;
    for (int i = 26; i >= 0; i--) begin
      if (!found && v[i]) begin
        n     = 5'(26 - i);
        found = 1'b1;
      end
    end
    return n;
  endfunction

  // Round a normalised 24-bit mantissa (hidden bit at [23]) with guard/round/
  // sticky, renormalise a rounding carry, then pack with overflow/underflow.
  function automatic logic [31:0] round_pack(
    input logic               sign,
    input logic signed [11:0] exp_in,
    input logic [23:0]        mant,
    input logic               g,
    input logic               r,
    input logic               s
  );
    logic               inc;
    logic [24:0]        mr;
    logic signed [11:0] e;
    logic [31:0]        res;
    inc = ROUND_NEAREST & g & (r | s | mant[0]);
    mr  = {1'b0, mant} + 25'(inc);
    e   = exp_in;
    if (mr[24]) begin
      mr = mr >> 1;
      e  = e + 12'sd1;
    end
    if (e >= 12'sd255) begin
      res = {sign, OVF_MAG};
    end else if (e <= 12'sd0) begin
      res = {sign, 31'd0};
    end else begin
      res = {sign, e[7:0], mr[22:0]};
    end
    return res;
  endfunction

  // ---------------------------------------------------------------------------
  // Operand classification
  // ---------------------------------------------------------------------------
  logic aa_zero, aa_inf, aa_nan, ab_zero, ab_inf, ab_nan;
  logic ma_zero, ma_inf, ma_nan, mb_zero, mb_inf, mb_nan;

  assign aa_zero = (bus.add_a[30:23] == 8'h00);
  assign aa_inf  = (bus.add_a[30:23] == 8'hFF) && (bus.add_a[22:0] == 23'd0);
  assign aa_nan  = (bus.add_a[30:23] == 8'hFF) && (bus.add_a[22:0] != 23'd0);
  assign ab_zero = (bus.add_b[30:23] == 8'h00);
  assign ab_inf  = (bus.add_b[30:23] == 8'hFF) && (bus.add_b[22:0] == 23'd0);
  assign ab_nan  = (bus.add_b[30:23] == 8'hFF) && (bus.add_b[22:0] != 23'd0);
  assign ma_zero = (bus.mul_a[30:23] == 8'h00);
  assign ma_inf  = (bus.mul_a[30:23] == 8'hFF) && (bus.mul_a[22:0] == 23'd0);
  assign ma_nan  = (bus.mul_a[30:23] == 8'hFF) && (bus.mul_a[22:0] != 23'd0);
  assign mb_zero = (bus.mul_b[30:23] == 8'h00);
  assign mb_inf  = (bus.mul_b[30:23] == 8'hFF) && (bus.mul_b[22:0] == 23'd0);
  assign mb_nan  = (bus.mul_b[30:23] == 8'hFF) && (bus.mul_b[22:0] != 23'd0);

  // ---------------------------------------------------------------------------
  // Adder
  // ---------------------------------------------------------------------------
  logic               add_swap;
  logic               al_sign;
  logic [7:0]         al_exp, as_exp;
  logic [23:0]        al_man, as_man;
  logic [7:0]         add_d;
  logic [4:0]         add_sh;
  logic [50:0]        add_wide;
  logic [26:0]        add_small;
  logic               add_eff_sub;
  logic [27:0]        add_raw;
  logic [4:0]         add_lz;
  logic [26:0]        add_norm;
  logic signed [11:0] add_exp;
  logic [31:0]        add_res;

  // Align the smaller operand, add/subtract, normalise, round and handle specials.
  always_comb begin
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    add_lz   = 5'd0;
    add_norm = 27'd0;
    add_exp  = 12'sd0;
    add_res  = 32'd0;

    add_swap = (bus.add_b[30:0] > bus.add_a[30:0]);
    al_sign  = add_swap ? bus.add_b[31]    : bus.add_a[31];
    al_exp   = add_swap ? bus.add_b[30:23] : bus.add_a[30:23];
    as_exp   = add_swap ? bus.add_a[30:23] : bus.add_b[30:23];
    al_man   = add_swap ? {1'b1, bus.add_b[22:0]} : {1'b1, bus.add_a[22:0]};
    as_man   = add_swap ? {1'b1, bus.add_a[22:0]} : {1'b1, bus.add_b[22:0]};

    // Shifts beyond 27 place the whole small mantissa below the sticky bit.
    add_d     = al_exp - as_exp;
    add_sh    = (add_d > 8'd27) ? 5'd27 : add_d[4:0];
    add_wide  = {as_man, 27'd0} >> add_sh;
    add_small = add_wide[50:24] | {26'd0, |add_wide[23:0]};

    add_eff_sub = bus.add_a[31] ^ bus.add_b[31];
    add_raw     = add_eff_sub ? ({1'b0, al_man, 3'b000} - {1'b0, add_small})
                              : ({1'b0, al_man, 3'b000} + {1'b0, add_small});

    if (add_raw[27]) begin
      add_norm = {add_raw[27:2], add_raw[1] | add_raw[0]};
      add_exp  = $signed({4'd0, al_exp}) + 12'sd1;
    end else begin
      add_lz   = lzc27(add_raw[26:0]);
      add_norm = add_raw[26:0] << add_lz;
      add_exp  = $signed({4'd0, al_exp}) - $signed({7'd0, add_lz});
    end

    if (aa_nan || ab_nan) begin
      add_res = QNAN;
    end else if (aa_inf && ab_inf) begin
      add_res = add_eff_sub ? QNAN : {bus.add_a[31], 8'hFF, 23'd0};
    end else if (aa_inf) begin
      add_res = {bus.add_a[31], 8'hFF, 23'd0};
    end else if (ab_inf) begin
      add_res = {bus.add_b[31], 8'hFF, 23'd0};
    end else if (aa_zero && ab_zero) begin
      add_res = {bus.add_a[31] & bus.add_b[31], 31'd0};
    end else if (aa_zero) begin
      add_res = bus.add_b;
    end else if (ab_zero) begin
      add_res = bus.add_a;
    end else if (add_raw == 28'd0) begin
      add_res = 32'd0;
    end else begin
      add_res = round_pack(al_sign, add_exp, add_norm[26:3],
                           add_norm[2], add_norm[1], add_norm[0]);
    end
  end

  assign bus.sum = add_res;

  // ---------------------------------------------------------------------------
  // Multiplier
  // ---------------------------------------------------------------------------
  logic               mul_sign;
  logic [47:0]        mul_prod;
  logic signed [11:0] mul_exp;
  logic [31:0]        mul_res;
  logic [31:0]        p_q;

  // Multiply mantissas, normalise by at most one bit, round and handle specials.
  always_comb begin
    mul_res  = 32'd0;
    mul_sign = bus.mul_a[31] ^ bus.mul_b[31];
    mul_prod = {1'b1, bus.mul_a[22:0]} * {1'b1, bus.mul_b[22:0]};
    mul_exp  = $signed({4'd0, bus.mul_a[30:23]}) + $signed({4'd0, bus.mul_b[30:23]})
             - 12'sd127;

    if (ma_nan || mb_nan) begin
      mul_res = QNAN;
    end else if ((ma_inf && mb_zero) || (ma_zero && mb_inf)) begin
      mul_res = QNAN;
    end else if (ma_inf || mb_inf) begin
      mul_res = {mul_sign, 8'hFF, 23'd0};
    end else if (ma_zero || mb_zero) begin
      mul_res = {mul_sign, 31'd0};
    end else if (mul_prod[47]) begin
      mul_res = round_pack(mul_sign, mul_exp + 12'sd1, mul_prod[47:24],
                           mul_prod[23], mul_prod[22], |mul_prod[21:0]);
    end else begin
      mul_res = round_pack(mul_sign, mul_exp, mul_prod[46:23],
                           mul_prod[22], mul_prod[21], |mul_prod[20:0]);
    end
  end

  // Product register; reset takes priority over a new product.
  always_ff @(posedge clk) begin
    // NOTE: clocked state uses non-blocking assignments so all registers update together.
    if (rst) begin
      p_q <= 32'd0;
    end else begin
      p_q <= mul_res;
    end
  end

  assign bus.p = p_q;

endmodule

// File: tb/tb_fp32_add_mul_unit.sv
// tb_fp32_add_mul_unit: table-driven bench for the binary32 add/multiply pair.
// Adder vectors are checked in the same cycle; multiplier expectations go into
// a scoreboard queue when operands are driven and are popped one edge later.
module tb_fp32_add_mul_unit;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] want;
  } vec_t;

`ifdef FP_ROUND_NEAREST_EN
  localparam logic [31:0] ADD_TIE_ODD = 32'h3F80_0002;
  localparam logic [31:0] ADD_OVF     = 32'h7F80_0000;
  localparam logic [31:0] MUL_OVF     = 32'h7F80_0000;
  localparam logic [31:0] MUL_TIE_ODD = 32'h3FC0_0002;
`else
  localparam logic [31:0] ADD_TIE_ODD = 32'h3F80_0001;
  localparam logic [31:0] ADD_OVF     = 32'h7F7F_FFFF;
  localparam logic [31:0] MUL_OVF     = 32'h7F7F_FFFF;
  localparam logic [31:0] MUL_TIE_ODD = 32'h3FC0_0001;
`endif

  localparam int N_ADD = 14;
  localparam int N_MUL = 13;

  logic clk;
  logic rst;
  fp32_add_mul_unit_if bus ();

  fp32_add_mul_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int pass_cnt  = 0;
  int total_cnt = 0;
  logic [31:0] sb_q[$];
  vec_t add_vecs[N_ADD];
  vec_t mul_vecs[N_MUL];

  task automatic check(input string name, input int idx,
                       input logic [31:0] got, input logic [31:0] want);
    total_cnt++;
    if (got === want) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s[%0d]: got %08h, expected %08h", name, idx, got, want);
    end
  endtask

  // One multiplier step: drive at the falling edge, queue the expectation,
  // compare the registered product just after the next rising edge.
  task automatic mul_step(input string name, input int idx, input logic rst_v,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] want);
    logic [31:0] exp_v;
    @(negedge clk);
    rst       = rst_v;
    bus.mul_a = a;
    bus.mul_b = b;
    sb_q.push_back(want);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      total_cnt++;
      $display("FAIL %s[%0d]: scoreboard empty", name, idx);
    end else begin
      exp_v = sb_q.pop_front();
      check(name, idx, bus.p, exp_v);
    end
  endtask

  initial begin
    add_vecs[0]  = '{32'h4480_0000, 32'h0000_0000, 32'h4480_0000}; // 1024 + 0
    add_vecs[1]  = '{32'h4480_0000, 32'hC480_0000, 32'h0000_0000}; // exact cancel
    add_vecs[2]  = '{32'h4480_0000, 32'h4480_0000, 32'h4500_0000}; // carry-out
    add_vecs[3]  = '{32'h3F80_0001, 32'h3380_0000, ADD_TIE_ODD};   // tie, odd lsb
    add_vecs[4]  = '{32'h3F80_0000, 32'h3380_0000, 32'h3F80_0000}; // tie, even lsb
    add_vecs[5]  = '{32'h7F80_0000, 32'hFF80_0000, 32'h7FC0_0000}; // Inf - Inf
    add_vecs[6]  = '{32'h7F80_0000, 32'h3F80_0000, 32'h7F80_0000}; // Inf + finite
    add_vecs[7]  = '{32'h8000_0000, 32'h0000_0000, 32'h0000_0000}; // -0 + +0
    add_vecs[8]  = '{32'h7FC0_0001, 32'h3F80_0000, 32'h7FC0_0000}; // NaN operand
    add_vecs[9]  = '{32'h3F80_0000, 32'hBF00_0000, 32'h3F00_0000}; // 1 - 0.5
    add_vecs[10] = '{32'h0000_0001, 32'h3F80_0000, 32'h3F80_0000}; // subnormal = 0
    add_vecs[11] = '{32'h7F7F_FFFF, 32'h7F7F_FFFF, ADD_OVF};       // overflow
    add_vecs[12] = '{32'hBFC0_0000, 32'h3E80_0000, 32'hBFA0_0000}; // -1.5 + 0.25
    add_vecs[13] = '{32'h8000_0000, 32'h8000_0000, 32'h8000_0000}; // -0 + -0

    mul_vecs[0]  = '{32'h4480_0000, 32'h4200_0000, 32'h4700_0000}; // 1024 * 32
    mul_vecs[1]  = '{32'h4500_0000, 32'h4200_0000, 32'h4780_0000}; // 2048 * 32
    mul_vecs[2]  = '{32'h7F00_0000, 32'h7F00_0000, MUL_OVF};       // overflow
    mul_vecs[3]  = '{32'h7FC0_0001, 32'h3F80_0000, 32'h7FC0_0000}; // NaN operand
    mul_vecs[4]  = '{32'h0000_0000, 32'h7F80_0000, 32'h7FC0_0000}; // 0 * Inf
    mul_vecs[5]  = '{32'hFF80_0000, 32'h3F80_0000, 32'hFF80_0000}; // -Inf * 1
    mul_vecs[6]  = '{32'h8000_0000, 32'h3F80_0000, 32'h8000_0000}; // -0 * 1
    mul_vecs[7]  = '{32'hBFC0_0000, 32'h4000_0000, 32'hC040_0000}; // -1.5 * 2
    mul_vecs[8]  = '{32'h0080_0000, 32'h0080_0000, 32'h0000_0000}; // underflow
    mul_vecs[9]  = '{32'h8080_0000, 32'h0080_0000, 32'h8000_0000}; // -underflow
    mul_vecs[10] = '{32'h3FFF_FFFF, 32'h3FFF_FFFF, 32'h407F_FFFE}; // 1-bit normalise
    mul_vecs[11] = '{32'h3FC0_0000, 32'h3F80_0001, MUL_TIE_ODD};   // tie, odd lsb
    mul_vecs[12] = '{32'h3F80_0001, 32'h3F80_0001, 32'h3F80_0002}; // sticky only

    rst       = 1'b1;
    bus.add_a = 32'd0;
    bus.add_b = 32'd0;
    bus.mul_a = 32'h4480_0000;
    bus.mul_b = 32'h4200_0000;

    // Reset state: product register cleared by the first edge with rst high.
    @(posedge clk);
    #1;
    check("reset_p", 0, bus.p, 32'h0000_0000);

    // Adder: combinational, compared in the same cycle it is driven.
    for (int i = 0; i < N_ADD; i++) begin
      @(negedge clk);
      bus.add_a = add_vecs[i].a;
      bus.add_b = add_vecs[i].b;
      #1;
      check("add", i, bus.sum, add_vecs[i].want);
    end

    // Multiplier: one-edge latency through the scoreboard.
    for (int i = 0; i < N_MUL; i++) begin
      mul_step("mul", i, 1'b0, mul_vecs[i].a, mul_vecs[i].b, mul_vecs[i].want);
    end

    // Mid-operation reset overrides the product, then the next edge resumes.
    mul_step("mid_rst", 0, 1'b1, 32'h4480_0000, 32'h4200_0000, 32'h0000_0000);
    mul_step("mid_rst", 1, 1'b0, 32'h4480_0000, 32'h4200_0000, 32'h4700_0000);
    mul_step("mid_rst", 2, 1'b0, 32'h4500_0000, 32'h4200_0000, 32'h4780_0000);

    // Adder keeps working while reset is asserted (no reset on sum).
    @(negedge clk);
    rst       = 1'b1;
    bus.add_a = 32'h4480_0000;
    bus.add_b = 32'h4480_0000;
    #1;
    check("add_in_rst", 0, bus.sum, 32'h4500_0000);
    @(negedge clk);
    rst = 1'b0;

    total_cnt++;
    if (sb_q.size() == 0) begin
      pass_cnt++;
    end else begin
      $display("FAIL scoreboard_drain: got %0d left, expected 0", sb_q.size());
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
